// File: rtl/muxn_rr_st_pkg.sv
// Shared constants for the mux family: the selection-mode encoding
// used on every Mode port, so later muxes decode it the same way.
package muxn_rr_st_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

endpackage

// File: rtl/muxn_rr_st_rr_pick.sv
// Rotating-priority picker: returns the first requester at or after
// ptr, wrapping past N-1 back to 0. Purely combinational so it can be
// dropped into any arbiter that keeps its own pointer register.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int w_idx;

  // Walk N slots starting at ptr; the explicit subtract-N wrap keeps
  // non-power-of-two channel counts correct.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(ptr) + i;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!gnt_any && (w_idx < N) && req[w_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/muxn_rr_st.sv
// N-to-1 registered mux with valid/ready on every channel. Mode picks
// between a fixed select and round-robin arbitration; one output
// register gives a 1-cycle latency at full throughput.
module muxn_rr_st
  import muxn_rr_st_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N*WIDTH-1:0] In,
  input  logic [N-1:0]       InValid,
  output logic [N-1:0]       InReady,
  input  logic [SEL_W-1:0]   S,
  input  logic               Mode,
  output logic [WIDTH-1:0]   Out,
  output logic [SEL_W-1:0]   OutSel,
  output logic               OutValid,
  input  logic               OutReady
);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_out;
  logic [SEL_W-1:0] r_outSel;
  logic             r_outValid;

  logic [SEL_W-1:0] w_rrIdx;
  logic             w_rrAny;
  logic             w_fixAny;
  logic [SEL_W-1:0] w_gntIdx;
  logic             w_gntAny;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gntData;
  logic [SEL_W-1:0] w_ptrNext;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rrPick (
    .req     (InValid),
    .ptr     (r_ptr),
    .gnt_idx (w_rrIdx),
    .gnt_any (w_rrAny)
  );

  // Fixed-mode grant: an out-of-range select never grants, even when
  // N is not a power of two and S can encode extra values.
  always_comb begin
    w_fixAny = 1'b0;
    if (int'(S) < N) begin
      w_fixAny = InValid[S];
    end
  end

  // Mode mux between the fixed select and the round-robin picker.
  always_comb begin
    w_gntIdx = S;
    w_gntAny = w_fixAny;
    if (Mode == MODE_RR) begin
      w_gntIdx = w_rrIdx;
      w_gntAny = w_rrAny;
    end
  end

  // The output stage can take a word when empty or draining this cycle;
  // reset blocks all transfers so InReady is quiet during Rst.
  assign w_load = !r_outValid || OutReady;
  assign w_xfer = !Rst && w_load && w_gntAny;

  // Per-channel ready and selected data, one-hot on the granted index.
  always_comb begin
    InReady   = '0;
    w_gntData = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gntIdx == SEL_W'(k)) begin
        InReady[k] = w_xfer;
        w_gntData  = In[k*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves one past the winner with an explicit wrap at N-1.
  assign w_ptrNext = (int'(w_gntIdx) == N - 1) ? '0 : w_gntIdx + SEL_W'(1);

  // Output register and round-robin pointer; reset wins over everything.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out      <= '0;
      r_outSel   <= '0;
      r_outValid <= 1'b0;
      r_ptr      <= '0;
    end else if (w_xfer) begin
      r_out      <= w_gntData;
      r_outSel   <= w_gntIdx;
      r_outValid <= 1'b1;
      if (Mode == MODE_RR) begin
        r_ptr <= w_ptrNext;
      end
    end else if (r_outValid && OutReady) begin
      r_outValid <= 1'b0;
    end
  end

  assign Out      = r_out;
  assign OutSel   = r_outSel;
  assign OutValid = r_outValid;

endmodule

// File: tb/tb_muxn_rr_st.sv
// Directed bench for muxn_rr_st: a 4-channel instance for the main
// scenarios and a 3-channel instance for the non-power-of-two wrap.
module tb_muxn_rr_st;

  logic        Clk;
  logic        Rst;

  logic [31:0] In4;
  logic [3:0]  InValid4;
  logic [3:0]  InReady4;
  logic [1:0]  S4;
  logic        Mode4;
  logic [7:0]  Out4;
  logic [1:0]  OutSel4;
  logic        OutValid4;
  logic        OutReady4;

  logic [23:0] In3;
  logic [2:0]  InValid3;
  logic [2:0]  InReady3;
  logic [1:0]  S3;
  logic        Mode3;
  logic [7:0]  Out3;
  logic [1:0]  OutSel3;
  logic        OutValid3;
  logic        OutReady3;

  int errors = 0;
  int checks = 0;

  muxn_rr_st #(.WIDTH(8), .N(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .In(In4), .InValid(InValid4), .InReady(InReady4),
    .S(S4), .Mode(Mode4), .Out(Out4), .OutSel(OutSel4), .OutValid(OutValid4),
    .OutReady(OutReady4)
  );

  muxn_rr_st #(.WIDTH(8), .N(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .In(In3), .InValid(InValid3), .InReady(InReady3),
    .S(S3), .Mode(Mode3), .Out(Out3), .OutSel(OutSel3), .OutValid(OutValid3),
    .OutReady(OutReady3)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance past the next rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; InValid4 = 4'b1111; OutReady4 = 1'b1; Mode4 = 1'b1; S4 = 2'd0;
    In4 = 32'h13121110;
    InValid3 = 3'b000; OutReady3 = 1'b1; Mode3 = 1'b0; S3 = 2'd0; In3 = 24'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (InReady4 !== 4'b0000) begin
        errors++; $display("[TB] FAIL reset_inready cyc%0d: got %b want 0000", c, InReady4);
      end
      checks++;
      if ({Out4, OutSel4, OutValid4} !== 11'd0) begin
        errors++; $display("[TB] FAIL reset_outputs cyc%0d: got out=%h sel=%0d v=%b want 0/0/0",
                           c, Out4, OutSel4, OutValid4);
      end
    end
    Rst = 1'b0; InValid4 = 4'b0000;
    #1;
  endtask

  task automatic test_fixed();
    Mode4 = 1'b0; S4 = 2'd2; In4 = 32'h00A50000; InValid4 = 4'b0100; OutReady4 = 1'b1;
    #1;
    checks++;
    if (InReady4 !== 4'b0100) begin
      errors++; $display("[TB] FAIL fixed_inready: got %b want 0100", InReady4);
    end
    tick();
    checks++;
    if (Out4 !== 8'hA5 || OutSel4 !== 2'd2 || OutValid4 !== 1'b1) begin
      errors++; $display("[TB] FAIL fixed_out: got out=%h sel=%0d v=%b want a5/2/1",
                         Out4, OutSel4, OutValid4);
    end
    S4 = 2'd3;
    #1;
    checks++;
    if (InReady4 !== 4'b0000) begin
      errors++; $display("[TB] FAIL fixed_nogrant_ready: got %b want 0000", InReady4);
    end
    tick();
    checks++;
    if (OutValid4 !== 1'b0 || Out4 !== 8'hA5 || OutSel4 !== 2'd2) begin
      errors++; $display("[TB] FAIL fixed_drain: got out=%h sel=%0d v=%b want a5/2/0",
                         Out4, OutSel4, OutValid4);
    end
    InValid4 = 4'b0000;
  endtask

  task automatic test_rr_fair();
    logic [1:0] expSel;
    Mode4 = 1'b1; In4 = 32'h13121110; InValid4 = 4'b1111; OutReady4 = 1'b1;
    #1;
    checks++;
    if (InReady4 !== 4'b0001) begin
      errors++; $display("[TB] FAIL rr_first_ready: got %b want 0001", InReady4);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      expSel = 2'(i % 4);
      checks++;
      if (OutSel4 !== expSel || Out4 !== (8'h10 + 8'(expSel)) || OutValid4 !== 1'b1) begin
        errors++; $display("[TB] FAIL rr_fair word%0d: got sel=%0d out=%h v=%b want sel=%0d out=%h v=1",
                           i, OutSel4, Out4, OutValid4, expSel, 8'h10 + 8'(expSel));
      end
    end
    InValid4 = 4'b0000;
    tick();
    checks++;
    if (OutValid4 !== 1'b0) begin
      errors++; $display("[TB] FAIL rr_fair_drain: got v=%b want 0", OutValid4);
    end
  endtask

  task automatic test_rr_skip_wrap();
    InValid4 = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (OutSel4 !== 2'(i)) begin
        errors++; $display("[TB] FAIL rr_advance word%0d: got sel=%0d want %0d", i, OutSel4, i);
      end
    end
    InValid4 = 4'b0101;
    #1;
    checks++;
    if (InReady4 !== 4'b0001) begin
      errors++; $display("[TB] FAIL rr_skip_wrap_ready: got %b want 0001", InReady4);
    end
    tick();
    checks++;
    if (OutSel4 !== 2'd0 || Out4 !== 8'h10) begin
      errors++; $display("[TB] FAIL rr_skip_wrap_out: got sel=%0d out=%h want 0/10", OutSel4, Out4);
    end
    checks++;
    if (InReady4 !== 4'b0100) begin
      errors++; $display("[TB] FAIL rr_skip_next_ready: got %b want 0100", InReady4);
    end
    tick();
    checks++;
    if (OutSel4 !== 2'd2 || Out4 !== 8'h12) begin
      errors++; $display("[TB] FAIL rr_skip_next_out: got sel=%0d out=%h want 2/12", OutSel4, Out4);
    end
    InValid4 = 4'b0000;
    tick();

    // Three-channel instance: winner ch2 must wrap the pointer to 0.
    Mode3 = 1'b1; In3 = 24'h222120; InValid3 = 3'b100;
    #1;
    checks++;
    if (InReady3 !== 3'b100) begin
      errors++; $display("[TB] FAIL n3_ready_ch2: got %b want 100", InReady3);
    end
    tick();
    checks++;
    if (OutSel3 !== 2'd2 || Out3 !== 8'h22) begin
      errors++; $display("[TB] FAIL n3_out_ch2: got sel=%0d out=%h want 2/22", OutSel3, Out3);
    end
    InValid3 = 3'b111;
    #1;
    checks++;
    if (InReady3 !== 3'b001) begin
      errors++; $display("[TB] FAIL n3_wrap_ready: got %b want 001", InReady3);
    end
    tick();
    checks++;
    if (OutSel3 !== 2'd0 || Out3 !== 8'h20) begin
      errors++; $display("[TB] FAIL n3_wrap_out: got sel=%0d out=%h want 0/20", OutSel3, Out3);
    end
    Mode3 = 1'b0; S3 = 2'd3;
    #1;
    checks++;
    if (InReady3 !== 3'b000) begin
      errors++; $display("[TB] FAIL n3_sel_out_of_range: got %b want 000", InReady3);
    end
    InValid3 = 3'b000;
  endtask

  task automatic test_backpressure();
    Mode4 = 1'b1; In4 = 32'h3C121110; InValid4 = 4'b1000; OutReady4 = 1'b0;
    tick();
    checks++;
    if (Out4 !== 8'h3C || OutSel4 !== 2'd3 || OutValid4 !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_load: got out=%h sel=%0d v=%b want 3c/3/1",
                         Out4, OutSel4, OutValid4);
    end
    InValid4 = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (InReady4 !== 4'b0000) begin
        errors++; $display("[TB] FAIL bp_inready cyc%0d: got %b want 0000", c, InReady4);
      end
      tick();
      checks++;
      if (Out4 !== 8'h3C || OutSel4 !== 2'd3 || OutValid4 !== 1'b1) begin
        errors++; $display("[TB] FAIL bp_hold cyc%0d: got out=%h sel=%0d v=%b want 3c/3/1",
                           c, Out4, OutSel4, OutValid4);
      end
    end
    OutReady4 = 1'b1;
    #1;
    checks++;
    if (InReady4 !== 4'b0001) begin
      errors++; $display("[TB] FAIL bp_release_ready: got %b want 0001", InReady4);
    end
    tick();
    checks++;
    if (Out4 !== 8'h10 || OutSel4 !== 2'd0 || OutValid4 !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_back_to_back: got out=%h sel=%0d v=%b want 10/0/1",
                         Out4, OutSel4, OutValid4);
    end
  endtask

  task automatic test_mid_reset();
    InValid4 = 4'b0010;
    tick();
    checks++;
    if (OutSel4 !== 2'd1 || OutValid4 !== 1'b1) begin
      errors++; $display("[TB] FAIL mr_setup: got sel=%0d v=%b want 1/1", OutSel4, OutValid4);
    end
    Rst = 1'b1; InValid4 = 4'b1111;
    #1;
    checks++;
    if (InReady4 !== 4'b0000) begin
      errors++; $display("[TB] FAIL mr_inready: got %b want 0000", InReady4);
    end
    tick();
    checks++;
    if (Out4 !== 8'h00 || OutSel4 !== 2'd0 || OutValid4 !== 1'b0) begin
      errors++; $display("[TB] FAIL mr_cleared: got out=%h sel=%0d v=%b want 0/0/0",
                         Out4, OutSel4, OutValid4);
    end
    Rst = 1'b0;
    #1;
    checks++;
    if (InReady4 !== 4'b0001) begin
      errors++; $display("[TB] FAIL mr_ptr_zero_ready: got %b want 0001", InReady4);
    end
    tick();
    checks++;
    if (OutSel4 !== 2'd0 || Out4 !== 8'h10 || OutValid4 !== 1'b1) begin
      errors++; $display("[TB] FAIL mr_first_grant: got sel=%0d out=%h v=%b want 0/10/1",
                         OutSel4, Out4, OutValid4);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_skip_wrap();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
